// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber coefficient constants for the multiply/reduce datapath
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int COEF_W = 12;
    localparam int PROD_W = 2 * COEF_W;
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/coef_mul_pipe_stage.sv
// pipe_stage: one valid/ready register slice; data only loads when the slice advances with valid input
module pipe_stage
    import kyber_pkg::*;
#(
    parameter int W = PROD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_vld,
    output logic         o_rdy,
    input  logic [W-1:0] i_data,
    output logic         o_vld,
    input  logic         i_rdy,
    output logic [W-1:0] o_data
);

    logic         r_vld;
    logic [W-1:0] r_data;
    logic         w_adv;

    assign w_adv  = ~r_vld | i_rdy;
    assign o_rdy  = w_adv;
    assign o_vld  = r_vld;
    assign o_data = r_data;

    // Slice register: refill when empty or when the successor takes the current word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (w_adv) begin
            r_vld <= i_vld;
            if (i_vld) r_data <= i_data;
        end
    end

endmodule

// File: rtl/coef_mul_pipe.sv
// coef_mul_pipe: two-stage unreduced coefficient multiplier (S1 operands, S2 product); COEF_MUL_STALL_CNT_EN adds a saturating backpressure counter
module coef_mul_pipe
    import kyber_pkg::*;
#(
    parameter int DW = COEF_W,
    parameter int PW = PROD_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          out_vld,
    input  logic          out_rdy,
`ifdef COEF_MUL_STALL_CNT_EN
    output logic [PW-1:0] prod,
    output logic [15:0]   stall_cnt
`else
    output logic [PW-1:0] prod
`endif
);

    logic            w_s1_rdy;
    logic            w_s1_vld;
    logic [2*DW-1:0] w_s1_data;
    logic            w_s2_rdy;
    logic [PW-1:0]   w_prod;

    // Input is refused during reset so nothing can slip in on the reset edge
    assign in_rdy = w_s1_rdy & ~rst;

    // Operands are zero-extended to the product width so the full product is kept
    assign w_prod = PW'(w_s1_data[2*DW-1:DW]) * PW'(w_s1_data[DW-1:0]);

    pipe_stage #(.W(2 * DW)) u_s1 (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (in_vld),
        .o_rdy  (w_s1_rdy),
        .i_data ({a, b}),
        .o_vld  (w_s1_vld),
        .i_rdy  (w_s2_rdy),
        .o_data (w_s1_data)
    );

    pipe_stage #(.W(PW)) u_s2 (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_s1_vld),
        .o_rdy  (w_s2_rdy),
        .i_data (w_prod),
        .o_vld  (out_vld),
        .i_rdy  (out_rdy),
        .o_data (prod)
    );

`ifdef COEF_MUL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    assign stall_cnt = r_stall_cnt;

    // Count edges where a product is waiting but downstream refuses it, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) r_stall_cnt <= '0;
        else if (out_vld && !out_rdy && r_stall_cnt != STALL_MAX) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
`else
`endif

endmodule

// File: tb/tb_coef_mul_pipe.sv
// tb_coef_mul_pipe: directed and randomised checks of coef_mul_pipe (COEF_MUL_STALL_CNT_EN optional)
module tb_coef_mul_pipe;
    import kyber_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [11:0] a;
    logic [11:0] b;
    logic        out_vld;
    logic        out_rdy;
    logic [23:0] prod;
`ifdef COEF_MUL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_run;
    int n_fail;

    coef_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .a         (a),
        .b         (b),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
`ifdef COEF_MUL_STALL_CNT_EN
        .prod      (prod),
        .stall_cnt (stall_cnt)
`else
        .prod      (prod)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_vld = 1'b0;
        out_rdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_vld = 1'b1;
        a = 12'd7;
        b = 12'd9;
        out_rdy = 1'b1;
        tick();
        @(negedge clk);
        n_run++;
        if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_in_rdy got %b want 0", in_rdy); end
        n_run++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_out_vld got %b want 0", out_vld); end
        n_run++;
        if (prod !== 24'd0) begin n_fail++; $display("FAIL rst_prod got %0d want 0", prod); end
`ifdef COEF_MUL_STALL_CNT_EN
        n_run++;
        if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
`endif
        tick();
        rst = 1'b0;
        in_vld = 1'b0;
        @(negedge clk);
        n_run++;
        if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_rdy got %b want 1", in_rdy); end
        tick();
        @(negedge clk);
        n_run++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_ignored_vld got %b want 0", out_vld); end
        tick();
    endtask

    task automatic test_latency;
        do_reset();
        in_vld = 1'b1;
        a = 12'd3328;
        b = 12'd3328;
        out_rdy = 1'b1;
        @(negedge clk);
        n_run++;
        if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL lat_in_rdy got %b want 1", in_rdy); end
        tick();
        in_vld = 1'b0;
        a = 12'd0;
        b = 12'd0;
        @(negedge clk);
        n_run++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL lat_early got out_vld=%b want 0", out_vld); end
        tick();
        @(negedge clk);
        n_run++;
        if (out_vld !== 1'b1 || prod !== 24'd11075584) begin
            n_fail++;
            $display("FAIL lat_prod got vld=%b prod=%0d want vld=1 prod=11075584", out_vld, prod);
        end
        tick();
        @(negedge clk);
        n_run++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL lat_once got out_vld=%b want 0", out_vld); end
        tick();
    endtask

    task automatic test_corners;
        logic [11:0] va [2];
        logic [11:0] vb [2];
        logic [23:0] vp [2];
        va = '{12'd4095, 12'd0};
        vb = '{12'd4095, 12'd1234};
        vp = '{24'd16769025, 24'd0};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_vld = (k < 2);
            a = (k < 2) ? va[k] : 12'd0;
            b = (k < 2) ? vb[k] : 12'd0;
            @(negedge clk);
            if (k >= 2) begin
                n_run++;
                if (out_vld !== 1'b1 || prod !== vp[k-2]) begin
                    n_fail++;
                    $display("FAIL corner_%0d got vld=%b prod=%0d want vld=1 prod=%0d", k - 2, out_vld, prod, vp[k-2]);
                end
            end
            tick();
        end
        in_vld = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [11:0] va [3];
        logic [11:0] vb [3];
        logic [23:0] vp [3];
        va = '{12'd1, 12'd2, 12'd3329};
        vb = '{12'd1, 12'd3, 12'd1};
        vp = '{24'd1, 24'd6, 24'd3329};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            in_vld = (k < 3);
            a = (k < 3) ? va[k] : 12'd0;
            b = (k < 3) ? vb[k] : 12'd0;
            @(negedge clk);
            if (k < 3) begin
                n_run++;
                if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_in_rdy_%0d got %b want 1", k, in_rdy); end
            end
            if (k >= 2) begin
                n_run++;
                if (out_vld !== 1'b1 || prod !== vp[k-2]) begin
                    n_fail++;
                    $display("FAIL b2b_out_%0d got vld=%b prod=%0d want vld=1 prod=%0d", k - 2, out_vld, prod, vp[k-2]);
                end
            end
            tick();
        end
        in_vld = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [11:0] va [3];
        logic [11:0] vb [3];
        logic [23:0] vp [3];
        int p;
        logic exp_rdy;
        va = '{12'd1, 12'd2, 12'd3329};
        vb = '{12'd1, 12'd3, 12'd1};
        vp = '{24'd1, 24'd6, 24'd3329};
        p = 0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            out_rdy = (k >= 7);
            in_vld = (p < 3);
            a = (p < 3) ? va[p] : 12'd0;
            b = (p < 3) ? vb[p] : 12'd0;
            @(negedge clk);
            exp_rdy = (k <= 1) || (k >= 7);
            n_run++;
            if (in_rdy !== exp_rdy) begin n_fail++; $display("FAIL bp_in_rdy_c%0d got %b want %b", k, in_rdy, exp_rdy); end
            if (k >= 2 && k <= 6) begin
                n_run++;
                if (out_vld !== 1'b1 || prod !== 24'd1) begin
                    n_fail++;
                    $display("FAIL bp_hold_c%0d got vld=%b prod=%0d want vld=1 prod=1", k, out_vld, prod);
                end
            end
            if (k == 6) begin
                n_run++;
                if (p !== 2) begin n_fail++; $display("FAIL bp_accepted got %0d want 2", p); end
            end
`ifdef COEF_MUL_STALL_CNT_EN
            if (k == 7) begin
                n_run++;
                if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_stall_cnt got %0d want 5", stall_cnt); end
            end
`endif
            if (k >= 7) begin
                n_run++;
                if (out_vld !== 1'b1 || prod !== vp[k-7]) begin
                    n_fail++;
                    $display("FAIL bp_out_%0d got vld=%b prod=%0d want vld=1 prod=%0d", k - 7, out_vld, prod, vp[k-7]);
                end
            end
            if (in_vld && in_rdy) p++;
            tick();
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        n_run++;
        if (p !== 3) begin n_fail++; $display("FAIL bp_total_accepted got %0d want 3", p); end
    endtask

    task automatic test_reset_mid;
        logic stale;
        stale = 1'b0;
        do_reset();
        out_rdy = 1'b0;
        in_vld = 1'b1;
        a = 12'd9;
        b = 12'd9;
        tick();
        a = 12'd10;
        b = 12'd10;
        tick();
        rst = 1'b1;
        a = 12'd11;
        b = 12'd11;
        @(negedge clk);
        n_run++;
        if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_rdy got %b want 0", in_rdy); end
        tick();
        rst = 1'b0;
        in_vld = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        n_run++;
        if (out_vld !== 1'b0 || prod !== 24'd0) begin
            n_fail++;
            $display("FAIL mid_rst_clear got vld=%b prod=%0d want vld=0 prod=0", out_vld, prod);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            if (out_vld !== 1'b0) stale = 1'b1;
        end
        n_run++;
        if (stale !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stale got out_vld=1 want 0"); end
        tick();
        in_vld = 1'b1;
        a = 12'd5;
        b = 12'd7;
        tick();
        in_vld = 1'b0;
        tick();
        @(negedge clk);
        n_run++;
        if (out_vld !== 1'b1 || prod !== 24'd35) begin
            n_fail++;
            $display("FAIL mid_rst_fresh got vld=%b prod=%0d want vld=1 prod=35", out_vld, prod);
        end
        tick();
    endtask

    task automatic test_random;
        logic [23:0] q [$];
        logic [23:0] exp_p;
        logic [23:0] hold_p;
        logic        hold;
        int sent;
        int cyc;
        sent = 0;
        cyc = 0;
        hold = 1'b0;
        hold_p = '0;
        do_reset();
        while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
            in_vld = (sent < 10000) && ($urandom_range(0, 3) != 0);
            a = 12'($urandom_range(0, 4095));
            b = 12'($urandom_range(0, 4095));
            out_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (hold) begin
                n_run++;
                if (out_vld !== 1'b1 || prod !== hold_p) begin
                    n_fail++;
                    $display("FAIL rand_hold c%0d got vld=%b prod=%0d want vld=1 prod=%0d", cyc, out_vld, prod, hold_p);
                end
            end
            hold = out_vld && !out_rdy;
            hold_p = prod;
            if (out_vld && out_rdy) begin
                n_run++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra c%0d got prod=%0d want no output", cyc, prod);
                end else begin
                    exp_p = q.pop_front();
                    if (prod !== exp_p) begin
                        n_fail++;
                        $display("FAIL rand_prod c%0d got %0d want %0d", cyc, prod, exp_p);
                    end
                    n_run++;
                    if ((int'(prod) % KYBER_Q) != (int'(exp_p) % KYBER_Q)) begin
                        n_fail++;
                        $display("FAIL rand_modq c%0d got %0d want %0d", cyc, int'(prod) % KYBER_Q, int'(exp_p) % KYBER_Q);
                    end
                end
            end
            if (in_vld && in_rdy) begin
                q.push_back(24'(int'(a) * int'(b)));
                sent++;
            end
            tick();
            cyc++;
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        n_run++;
        if (sent != 10000 || q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_timeout got sent=%0d pending=%0d want sent=10000 pending=0", sent, q.size());
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        rst = 1'b1;
        in_vld = 1'b0;
        a = '0;
        b = '0;
        out_rdy = 1'b1;
        test_reset();
        test_latency();
        test_corners();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
